corescore_stream_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing one byte-wide AXI-Stream sink
//  (the UART emitter) between NUM_SOURCES byte-stream producers, e.g. several

---
 rtl/corescore_stream_arbiter.sv | 113 +++++++++++
 tb/tb_corescore_stream_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corescore_stream_arbiter.sv
// Packet-granular round-robin arbiter: NUM_SOURCES byte streams share one
// AXI-Stream sink; a grant is held from first beat until the tlast beat is accepted.
module corescore_stream_arbiter #(
  parameter int unsigned NUM_SOURCES = 4,
  localparam int unsigned GW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [8*NUM_SOURCES-1:0] i_tdata,
  input  logic [NUM_SOURCES-1:0]   i_tlast,
  input  logic [NUM_SOURCES-1:0]   i_tvalid,
  output logic [NUM_SOURCES-1:0]   o_tready,
  output logic [7:0]               o_tdata,
  output logic                     o_tlast,
  output logic                     o_tvalid,
  input  logic                     i_tready,
  output logic [GW-1:0]            o_grant,
  output logic                     o_busy,
  output logic [15:0]              o_pkt_cnt
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_ptr;
  logic [15:0]     r_pkt_cnt;

  logic [7:0]      w_tdata_arr [NUM_SOURCES];
  logic            w_found;
  logic [GW-1:0]   w_sel;
  logic            w_locked;
  logic [7:0]      w_cur_data;
  logic            w_cur_valid;
  logic            w_cur_last;
  logic            w_last_xfer;
  logic [GW-1:0]   w_ptr_next;

  // Unpack the flat per-source data bus.
  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_unpack
    assign w_tdata_arr[g] = i_tdata[8*g+7:8*g];
  end

  // Round-robin search: first requester at ptr, ptr+1, ... mod NUM_SOURCES.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
        if (!w_found && i_tvalid[GW'(s)] &&
            (s == ((32'(r_ptr) + k) % NUM_SOURCES))) begin
          w_found = 1'b1;
          w_sel   = GW'(s);
        end
      end
    end
  end

  assign w_locked    = (r_state == ST_LOCKED);
  assign w_cur_data  = w_tdata_arr[r_grant];
  assign w_cur_valid = i_tvalid[r_grant];
  assign w_cur_last  = i_tlast[r_grant];
  assign w_last_xfer = w_locked && w_cur_valid && i_tready && w_cur_last;
  assign w_ptr_next  = (r_grant == GW'(NUM_SOURCES - 1)) ? '0 : r_grant + GW'(1);

  // Zero-latency pass-through of the granted source while locked.
  always_comb begin
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_tdata  = '0;
    o_tready = '0;
    if (w_locked) begin
      o_tvalid = w_cur_valid;
      o_tlast  = w_cur_last;
      o_tdata  = w_cur_data;
      o_tready = NUM_SOURCES'(i_tready) << r_grant;
    end
  end

  assign o_busy    = w_locked;
  assign o_grant   = r_grant;
  assign o_pkt_cnt = r_pkt_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_sel;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_last_xfer) begin
            r_state   <= ST_IDLE;
            r_ptr     <= w_ptr_next;
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Randomized bench for corescore_stream_arbiter: AXI-compliant source drivers,
// a transaction-level arbiter model and a per-source byte scoreboard.
module tb_corescore_stream_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

  logic           clk;
  logic           rst_n;
  logic [8*N-1:0] tdata;
  logic [N-1:0]   tlast;
  logic [N-1:0]   tvalid;
  logic [N-1:0]   o_tready_w;
  logic [7:0]     o_tdata_w;
  logic           o_tlast_w;
  logic           o_tvalid_w;
  logic           tready;
  logic [GW-1:0]  grant_w;
  logic           busy_w;
  logic [15:0]    cnt_w;

  corescore_stream_arbiter #(.NUM_SOURCES(N)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_tdata   (tdata),
    .i_tlast   (tlast),
    .i_tvalid  (tvalid),
    .o_tready  (o_tready_w),
    .o_tdata   (o_tdata_w),
    .o_tlast   (o_tlast_w),
    .o_tvalid  (o_tvalid_w),
    .i_tready  (tready),
    .o_grant   (grant_w),
    .o_busy    (busy_w),
    .o_pkt_cnt (cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_vec;
  int            n_err;
  logic [8:0]    src_q [N][$];
  logic [8:0]    exp_q [N][$];
  int unsigned   rate [N];
  int unsigned   rdy_rate;
  logic [N-1:0]  hs;
  bit            m_locked;
  int            m_owner;
  int            m_next;
  int            m_cnt;
  bit            prev_busy;
  int            grant_log [$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_idle();
    bit q_empty = 1'b1;
    for (int s = 0; s < N; s++) if (src_q[s].size() != 0) q_empty = 1'b0;
    return q_empty && !m_locked && (tvalid == '0);
  endfunction

  task automatic model_reset();
    m_locked  = 1'b0;
    m_owner   = 0;
    m_next    = 0;
    m_cnt     = 0;
    prev_busy = 1'b0;
    hs        = '0;
  endtask

  // One cycle: drive sources at negedge, check outputs, advance the model.
  task automatic step();
    logic [8:0]   b;
    logic         e_vld, e_last;
    logic [7:0]   e_data;
    logic [N-1:0] e_rdy;
    logic [8:0]   sb;
    bit           found;
    @(negedge clk);
    for (int s = 0; s < N; s++) begin
      if (hs[s]) tvalid[s] = 1'b0;
      if (!tvalid[s] && src_q[s].size() > 0 && $urandom_range(99) < rate[s]) begin
        b = src_q[s].pop_front();
        tdata[8*s +: 8] = b[7:0];
        tlast[s]  = b[8];
        tvalid[s] = 1'b1;
        exp_q[s].push_back(b);
      end
    end
    tready = ($urandom_range(99) < rdy_rate);
    #1;
    e_vld = 1'b0; e_last = 1'b0; e_data = '0; e_rdy = '0;
    if (m_locked) begin
      e_vld  = tvalid[m_owner];
      e_last = tlast[m_owner];
      e_data = tdata[8*m_owner +: 8];
      e_rdy  = tready ? (N'(1) << m_owner) : '0;
    end
    chk_eq("tvalid", 32'(o_tvalid_w), 32'(e_vld));
    chk_eq("tready", 32'(o_tready_w), 32'(e_rdy));
    chk_eq("tdata",  32'(o_tdata_w),  32'(e_data));
    chk_eq("tlast",  32'(o_tlast_w),  32'(e_last));
    chk_eq("busy",   32'(busy_w),     32'(m_locked));
    chk_eq("grant",  32'(grant_w),    32'(m_owner));
    chk_eq("pktcnt", 32'(cnt_w),      32'(m_cnt));
    if (busy_w && !prev_busy) grant_log.push_back(int'(grant_w));
    prev_busy = busy_w;
    // Sink-side scoreboard: each accepted byte is the next one its source issued.
    if (m_locked && tvalid[m_owner] && tready) begin
      if (exp_q[m_owner].size() == 0) chk_eq("sb_empty", 32'(1), 32'(0));
      else begin
        sb = exp_q[m_owner].pop_front();
        chk_eq("sb_byte", 32'({o_tlast_w, o_tdata_w}), 32'(sb));
      end
    end
    hs = tvalid & o_tready_w;
    if (!m_locked) begin
      if (tvalid != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && tvalid[(m_next + k) % N]) begin
            m_owner = (m_next + k) % N;
            found   = 1'b1;
          end
        end
        m_locked = 1'b1;
      end
    end else if (tvalid[m_owner] && tready && tlast[m_owner]) begin
      m_locked = 1'b0;
      m_next   = (m_owner + 1) % N;
      m_cnt    = (m_cnt + 1) % 65536;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!is_idle() && n < budget) begin
      step();
      n++;
    end
    chk_eq("drain_done", 32'(is_idle()), 32'(1));
    step();
  endtask

  task automatic gen_pkt(input int s);
    int len = int'($urandom_range(1, 5));
    for (int i = 0; i < len; i++) src_q[s].push_back({(i == len - 1), 8'($urandom)});
  endtask

  task automatic set_rates(input int unsigned r, input int unsigned rr);
    for (int s = 0; s < N; s++) rate[s] = r;
    rdy_rate = rr;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    set_rates(100, 100);
    rst_n  = 1'b0;
    tdata  = {N{8'hA5}};
    tlast  = '1;
    tvalid = '1;
    tready = 1'b1;

    // Reset with every source requesting.
    #3;
    chk_eq("rst_tvalid", 32'(o_tvalid_w), 32'(0));
    chk_eq("rst_tready", 32'(o_tready_w), 32'(0));
    chk_eq("rst_tdata",  32'(o_tdata_w),  32'(0));
    chk_eq("rst_busy",   32'(busy_w),     32'(0));
    chk_eq("rst_cnt",    32'(cnt_w),      32'(0));
    chk_eq("rst_grant",  32'(grant_w),    32'(0));
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_hold_busy", 32'(busy_w), 32'(0));
    tvalid = '0;
    tlast  = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single source packet 0x41 0x42 0x43.
    src_q[2].push_back(9'h041);
    src_q[2].push_back(9'h042);
    src_q[2].push_back(9'h143);
    drain(50);
    chk_eq("t2_cnt",   32'(cnt_w),   32'(1));
    chk_eq("t2_grant", 32'(grant_w), 32'(2));

    // Fairness: all sources stream 2-byte packets; rotation starts at 3.
    grant_log.delete();
    for (int p = 0; p < 6; p++)
      for (int s = 0; s < N; s++) begin
        src_q[s].push_back({1'b0, 8'(s * 16 + p)});
        src_q[s].push_back({1'b1, 8'(s * 16 + p + 8)});
      end
    drain(400);
    chk_eq("t3_npkts", 32'(grant_log.size()), 32'(24));
    for (int k = 0; k < grant_log.size(); k++)
      chk_eq("t3_order", 32'(grant_log[k]), 32'((3 + k) % 4));

    // Backpressure on src1 with src0 pending.
    grant_log.delete();
    set_rates(100, 50);
    for (int i = 0; i < 4; i++) src_q[1].push_back({(i == 3), 8'(8'h10 + i)});
    step();
    src_q[0].push_back(9'h1EE);
    drain(200);
    chk_eq("t4_n",     32'(grant_log.size()), 32'(2));
    chk_eq("t4_first", 32'(grant_log[0]), 32'(1));
    chk_eq("t4_next",  32'(grant_log[1]), 32'(0));

    // src3 stalls mid-packet while src0 waits; then ptr wraps to 0.
    grant_log.delete();
    set_rates(100, 100);
    src_q[3].push_back(9'h030);
    src_q[3].push_back(9'h031);
    repeat (4) step();
    src_q[0].push_back(9'h1C0);
    repeat (5) step();
    chk_eq("t5_busy",  32'(busy_w),  32'(1));
    chk_eq("t5_grant", 32'(grant_w), 32'(3));
    src_q[3].push_back(9'h132);
    drain(50);
    chk_eq("t5_n",    32'(grant_log.size()), 32'(2));
    chk_eq("t5_wrap", 32'(grant_log[1]), 32'(0));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        for (int s = 0; s < N; s++) rate[s] = $urandom_range(30, 100);
        rdy_rate = $urandom_range(40, 100);
      end
      for (int s = 0; s < N; s++)
        if (src_q[s].size() == 0 && $urandom_range(3) == 0) gen_pkt(s);
      step();
    end
    drain(3000);

    // Reset in the middle of a packet.
    set_rates(100, 100);
    for (int i = 0; i < 6; i++) src_q[1].push_back({(i == 5), 8'(8'h60 + i)});
    repeat (3) step();
    @(posedge clk);
    #2;
    chk_eq("t6_pre_busy", 32'(busy_w), 32'(1));
    rst_n = 1'b0;
    #1;
    chk_eq("t6_tvalid", 32'(o_tvalid_w), 32'(0));
    chk_eq("t6_tready", 32'(o_tready_w), 32'(0));
    chk_eq("t6_tlast",  32'(o_tlast_w),  32'(0));
    chk_eq("t6_busy",   32'(busy_w),     32'(0));
    chk_eq("t6_cnt",    32'(cnt_w),      32'(0));
    chk_eq("t6_grant",  32'(grant_w),    32'(0));
    tvalid = '0;
    tlast  = '0;
    for (int s = 0; s < N; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete();
    src_q[2].push_back(9'h070);
    src_q[2].push_back(9'h171);
    drain(50);
    chk_eq("t6_regrant", 32'(grant_log[0]), 32'(2));

    // Packet counter wrap.
    @(negedge clk);
    force dut.r_pkt_cnt = 16'hFFFD;
    #1;
    release dut.r_pkt_cnt;
    m_cnt = 16'hFFFD;
    #1;
    chk_eq("t7_preset", 32'(cnt_w), 32'(16'hFFFD));
    for (int i = 0; i < 4; i++) src_q[0].push_back({1'b1, 8'(8'h80 + i)});
    drain(50);
    chk_eq("t7_wrap", 32'(cnt_w), 32'(1));

    for (int s = 0; s < N; s++) chk_eq("sb_left", 32'(exp_q[s].size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
